// File: rtl/pe_cluster_pkg.sv
// Shared types and helpers for the PE cluster: reset FSM states and the
// circular next-enabled-PE search used by the slot arbiter.
package pe_cluster_pkg;

  // Largest supported cluster; the search function works on a mask this wide.
  localparam int MAX_PE = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SRST    = 2'd1,
    RELEASE = 2'd2
  } clst_state_t;

  // First set bit of mask after cur, searching cur+1, cur+2, ... and wrapping
  // at n. Returns cur itself when cur is the only enabled index, and also when
  // nothing is enabled (the caller never advances in that case).
  function automatic logic [3:0] next_en_idx(input logic [MAX_PE-1:0] mask,
                                             input logic [3:0]        cur,
                                             input int                n);
    logic [3:0] res;
    int         idx;
    res = cur;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int s = MAX_PE; s >= 1; s--) begin
      idx = int'(cur) + s;
      if (idx >= n) idx = idx - n;
      if ((s <= n) && mask[idx[3:0]]) res = idx[3:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pe.sv
// Minimal processing element as seen from the cluster: it latches its bus
// word every cycle it is out of reset, presents an address inside its own
// 256-byte window offset by that word, and requests a cluster soft reset when
// the latched word carries command nibble 4'hF in its top bits.
module pe #(
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int WORD_LEN  = 64,
  parameter int PE_ID     = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [BUS_WIDTH-1:0] bus_data_i,
  output logic [AD_LEN-1:0]    bus_ad_o,
  output logic                 reset_o
);

  logic [WORD_LEN-1:0] word_q;

  // Capture the incoming bus word; cleared whenever this PE is held in reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      word_q <= '0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values;
      // a blocking = here would let later logic in the block see the new value.
      word_q <= WORD_LEN'(bus_data_i);
    end
  end

  assign bus_ad_o = AD_LEN'(word_q) + (AD_LEN'(PE_ID) << 8);
  assign reset_o  = (word_q[BUS_WIDTH-1 -: 4] == 4'hF);

endmodule

// File: rtl/pe_cluster_slot_arb.sv
// Round-robin bus slot arbiter: owns the slot counter and the owner index,
// hops to the next enabled PE at slot end, and aborts a slot whose owner was
// disabled. Freezes when nothing is enabled or the cluster is not running.
module pe_slot_arb
  import pe_cluster_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int SLOT_CYCLES = 2,
  parameter int IDW         = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_PE-1:0] en_i,
  input  logic              run_i,
  input  logic              clr_i,
  output logic [IDW-1:0]    owner_o,
  output logic              capture_o
);

  localparam int SCW = $clog2(SLOT_CYCLES + 1);

  logic [SCW-1:0] slot_q, slot_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] nxt_owner;
  logic           any_en, owner_en, slot_last;

  assign any_en    = |en_i;
  assign owner_en  = en_i[owner_q];
  assign slot_last = (slot_q == SCW'(SLOT_CYCLES - 1));
  assign nxt_owner = IDW'(next_en_idx(MAX_PE'(en_i), 4'(owner_q), NUM_PE));

  // Next slot position and owner; capture strobes on a completed slot only.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the branches below leaves a value unassigned (no latch).
    slot_d    = slot_q;
    owner_d   = owner_q;
    capture_o = 1'b0;
    if (clr_i) begin
      slot_d  = '0;
      owner_d = '0;
    end else if (run_i && any_en) begin
      if (!owner_en) begin
        slot_d  = '0;
        owner_d = nxt_owner;
      end else if (slot_last) begin
        capture_o = 1'b1;
        slot_d    = '0;
        owner_d   = nxt_owner;
      end else begin
        slot_d = slot_q + SCW'(1);
      end
    end
  end

  // Slot counter and owner registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      slot_q  <= '0;
      owner_q <= '0;
    end else begin
      slot_q  <= slot_d;
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/pe_cluster.sv
// Cluster of NUM_PE processing elements sharing one bus. PEs get the bus in
// round-robin slots; each PE sees its last captured bus word from a hold
// register. A reset request from any enabled PE drives every PE through a
// common soft-reset sequence (SRST for RST_HOLD cycles, then one RELEASE).
module pe_cluster
  import pe_cluster_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int AD_LEN      = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int WORD_LEN    = 64,
  parameter int SLOT_CYCLES = 2,
  parameter int RST_HOLD    = 4,
  localparam int IDW        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_PE-1:0]    pe_en_i,
  input  logic [BUS_WIDTH-1:0] bus_data_i,
  output logic [AD_LEN-1:0]    bus_ad_o,
  output logic                 bus_valid_o,
  output logic [IDW-1:0]       slot_id_o,
  output logic                 busy_o,
  output logic                 reset_o
);

  localparam int RCW = $clog2(RST_HOLD + 1);

  clst_state_t          state_q, state_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [BUS_WIDTH-1:0] hold_q [NUM_PE];
  logic [AD_LEN-1:0]    pe_ad [NUM_PE];
  logic [NUM_PE-1:0]    pe_req;
  logic [NUM_PE-1:0]    pe_rst_n;
  logic [IDW-1:0]       owner;
  logic                 capture, run, clr, soft_req;
  logic [AD_LEN-1:0]    bus_ad_q, bus_ad_d;
  logic                 bus_valid_q, bus_valid_d;

  assign run      = (state_q == RUN);
  assign clr      = (state_d != RUN);
  assign soft_req = |(pe_en_i & pe_req);

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    assign pe_rst_n[k] = reset_i & pe_en_i[k] & run;
    pe #(
      .AD_LEN   (AD_LEN),
      .BUS_WIDTH(BUS_WIDTH),
      .WORD_LEN (WORD_LEN),
      .PE_ID    (k)
    ) u_pe (
      .clk_i     (clk_i),
      .reset_i   (pe_rst_n[k]),
      .bus_data_i(hold_q[k]),
      .bus_ad_o  (pe_ad[k]),
      .reset_o   (pe_req[k])
    );
  end

  pe_slot_arb #(
    .NUM_PE     (NUM_PE),
    .SLOT_CYCLES(SLOT_CYCLES),
    .IDW        (IDW)
  ) u_arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (pe_en_i),
    .run_i    (run),
    .clr_i    (clr),
    .owner_o  (owner),
    .capture_o(capture)
  );

  // Soft-reset sequencing: RUN -> SRST (RST_HOLD cycles) -> RELEASE -> RUN.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      RUN: begin
        if (soft_req) begin
          state_d   = SRST;
          rst_cnt_d = '0;
        end
      end
      SRST: begin
        if (rst_cnt_q == RCW'(RST_HOLD - 1)) state_d = RELEASE;
        else                                 rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      RELEASE: begin
        rst_cnt_d = '0;
        state_d   = RUN;
      end
      default: begin
        state_d   = RUN;
        rst_cnt_d = '0;
      end
    endcase
  end

  // FSM state and hold-count registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= RUN;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Per-PE hold registers: loaded at the end of the PE's own slot.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: this array is reset even though it is register-file shaped,
      // because every entry drives a live PE input and must start at zero.
      hold_q <= '{default: '0};
    end else if (clr) begin
      hold_q <= '{default: '0};
    end else if (capture) begin
      hold_q[owner] <= bus_data_i;
    end
  end

  assign bus_valid_d = (state_d == RUN) & pe_en_i[owner];
  assign bus_ad_d    = bus_valid_d ? pe_ad[owner] : '0;

  // Registered bus address/valid of the current slot owner.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bus_ad_q    <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      bus_ad_q    <= bus_ad_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign bus_ad_o    = bus_ad_q;
  assign bus_valid_o = bus_valid_q;
  assign slot_id_o   = owner;
  assign busy_o      = !run;
  assign reset_o     = run & soft_req;

endmodule

// File: tb/tb_pe_cluster.sv
// Scoreboard bench for pe_cluster (NUM_PE=4, SLOT_CYCLES=2, RST_HOLD=4).
// A cycle-level reference model predicts every output; expectations are
// queued by the stimulus process and popped by an independent monitor.
module tb_pe_cluster;

  localparam int NPE = 4;
  localparam int SC  = 2;
  localparam int RH  = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  pe_en_i;
  logic [31:0] bus_data_i;
  logic [31:0] bus_ad_o;
  logic        bus_valid_o;
  logic [1:0]  slot_id_o;
  logic        busy_o;
  logic        reset_o;

  pe_cluster #(
    .NUM_PE(NPE), .AD_LEN(32), .BUS_WIDTH(32), .WORD_LEN(64),
    .SLOT_CYCLES(SC), .RST_HOLD(RH)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pe_en_i    (pe_en_i),
    .bus_data_i (bus_data_i),
    .bus_ad_o   (bus_ad_o),
    .bus_valid_o(bus_valid_o),
    .slot_id_o  (slot_id_o),
    .busy_o     (busy_o),
    .reset_o    (reset_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ad;
    logic        valid;
    logic [1:0]  id;
    logic        busy;
    logic        rst;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  int          m_owner, m_slot, m_busy_left;
  logic [31:0] m_hold [NPE];
  logic [31:0] m_word [NPE];
  logic [31:0] m_ad;
  logic        m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_owner(input logic [3:0] en, input int cur);
    for (int s = 1; s <= NPE; s++) begin
      if (en[(cur + s) % NPE]) return (cur + s) % NPE;
    end
    return cur;
  endfunction

  function automatic logic [31:0] nrm();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  task automatic m_reset();
    m_owner = 0; m_slot = 0; m_busy_left = 0; m_ad = '0; m_valid = 1'b0;
    for (int k = 0; k < NPE; k++) begin m_hold[k] = '0; m_word[k] = '0; end
  endtask

  // Advance the model over one clock edge using the inputs seen before it.
  task automatic m_step();
    logic        run_old, req, nxt_run;
    logic [31:0] w_new [NPE];
    if (!reset_i) begin m_reset(); return; end
    run_old = (m_busy_left == 0);
    req = 1'b0;
    for (int k = 0; k < NPE; k++)
      if (pe_en_i[k] && m_word[k][31:28] == 4'hF) req = 1'b1;
    if (!run_old)  m_busy_left--;
    else if (req)  m_busy_left = RH + 1;
    nxt_run = (m_busy_left == 0);
    m_valid = nxt_run && pe_en_i[m_owner];
    m_ad    = m_valid ? m_word[m_owner] + (32'(m_owner) << 8) : 32'h0;
    for (int k = 0; k < NPE; k++) w_new[k] = (run_old && pe_en_i[k]) ? m_hold[k] : 32'h0;
    if (!nxt_run) begin
      for (int k = 0; k < NPE; k++) m_hold[k] = '0;
      m_owner = 0; m_slot = 0;
    end else if (run_old && pe_en_i != 4'b0) begin
      if (!pe_en_i[m_owner]) begin
        m_owner = next_owner(pe_en_i, m_owner); m_slot = 0;
      end else if (m_slot == SC - 1) begin
        m_hold[m_owner] = bus_data_i;
        m_owner = next_owner(pe_en_i, m_owner); m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    for (int k = 0; k < NPE; k++) m_word[k] = w_new[k];
  endtask

  task automatic push_exp();
    exp_t e;
    logic rq;
    rq = 1'b0;
    for (int k = 0; k < NPE; k++) begin
      if (m_busy_left != 0 || !pe_en_i[k]) m_word[k] = '0;
      if (pe_en_i[k] && m_word[k][31:28] == 4'hF) rq = 1'b1;
    end
    e.ad    = m_ad;
    e.valid = m_valid;
    e.id    = 2'(m_owner);
    e.busy  = (m_busy_left != 0);
    e.rst   = (m_busy_left == 0) && rq;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    m_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [31:0] d, input logic r);
    pe_en_i    = en;
    bus_data_i = d;
    reset_i    = r;
    if (!r) m_reset();
    push_exp();
  endtask

  task automatic cycle(input logic [3:0] en, input logic [31:0] d, input logic r);
    tick();
    drive(en, d, r);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("bus_ad",    bus_ad_o,    e.ad);
        check("bus_valid", bus_valid_o, e.valid);
        check("slot_id",   slot_id_o,   e.id);
        check("busy",      busy_o,      e.busy);
        check("reset_o",   reset_o,     e.rst);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int         g;
    logic [3:0] en_r;
    reset_i = 1'b0; pe_en_i = 4'h0; bus_data_i = '0;
    m_reset();

    // Reset state.
    cycle(4'h0, 32'h0, 1'b0);
    cycle(4'h0, 32'h0, 1'b0);

    // Full rotation with every PE enabled.
    for (int i = 0; i < 14; i++) cycle(4'hF, nrm(), 1'b1);

    // Only PE0/PE2 enabled.
    for (int i = 0; i < 10; i++) cycle(4'b0101, nrm(), 1'b1);

    // Disable everything mid-slot of PE2, then resume with PE3 only.
    g = 0; tick();
    while (!(m_owner == 2 && m_slot == 1) && g < 40) begin drive(4'hF, nrm(), 1'b1); tick(); g++; end
    drive(4'h0, nrm(), 1'b1);
    for (int i = 0; i < 4; i++) cycle(4'h0, nrm(), 1'b1);
    for (int i = 0; i < 6; i++) cycle(4'b1000, nrm(), 1'b1);

    // Arm reset commands in PE1 and PE3 while each is disabled, then
    // re-enable both together so they request in the same cycle.
    g = 0; tick();
    while (!(m_owner == 1 && m_slot == 1) && g < 40) begin drive(4'hF, nrm(), 1'b1); tick(); g++; end
    drive(4'hF, 32'hF000_0011, 1'b1);
    cycle(4'b1101, nrm(), 1'b1);
    g = 0; tick();
    while (!(m_owner == 3 && m_slot == 1) && g < 40) begin drive(4'b1101, nrm(), 1'b1); tick(); g++; end
    drive(4'b1101, 32'hF000_0033, 1'b1);
    cycle(4'b0101, nrm(), 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'hF, nrm(), 1'b1);

    // Async reset in the second SRST cycle, then normal rotation.
    g = 0; tick();
    while (m_busy_left == 0 && g < 20) begin
      drive(4'b0100, (g < 4) ? 32'hF0F0_0002 : nrm(), 1'b1);
      tick(); g++;
    end
    drive(4'b0100, nrm(), 1'b1);
    cycle(4'b0100, nrm(), 1'b0);
    cycle(4'b0100, nrm(), 1'b0);
    for (int i = 0; i < 12; i++) cycle(4'hF, nrm(), 1'b1);

    // Only PE2 enabled with a fixed data word.
    cycle(4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(4'b0100, 32'hA5A5_0001, 1'b1);

    // Randomised traffic: enables, data (including reset commands), resets.
    en_r = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) en_r = 4'($urandom_range(0, 15));
      cycle(en_r, $urandom, ($urandom_range(0, 199) != 0));
    end

    @(negedge clk_i);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
